// File: rtl/alu_core_pkg.sv
// Shared definitions for the 8-bit ALU: operation codes and condition-code bit positions.
package alu_core_pkg;

    localparam int unsigned DataWidth = 8;
    localparam int unsigned OpWidth   = 4;
    localparam int unsigned CcWidth   = 2;

    // Condition-code bit positions within cc
    localparam int unsigned FlagZ = 0;
    localparam int unsigned FlagC = 1;

    typedef enum logic [OpWidth-1:0] {
        OpAdd  = 4'd0,
        OpSub  = 4'd1,
        OpAnd  = 4'd2,
        OpOr   = 4'd3,
        OpXor  = 4'd4,
        OpNot  = 4'd5,
        OpShl  = 4'd6,
        OpShr  = 4'd7,
        OpSar  = 4'd8,
        OpRol  = 4'd9,
        OpRor  = 4'd10,
        OpInc  = 4'd11,
        OpDec  = 4'd12,
        OpPassA = 4'd13,
        OpPassB = 4'd14,
        OpCmp  = 4'd15
    } alu_op_e;

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU datapath: result and Z/C flags from operands and operation select.
module alu_comb
    import alu_core_pkg::*;
(
    input  logic [DataWidth-1:0] i_a,
    input  logic [DataWidth-1:0] i_b,
    input  logic [OpWidth-1:0]   i_op,
    output logic [DataWidth-1:0] o_result,
    output logic [CcWidth-1:0]   o_flags
);

    logic [DataWidth:0]   w_add;
    logic [DataWidth:0]   w_sub;
    logic [DataWidth:0]   w_inc;
    logic [DataWidth:0]   w_dec;
    logic [DataWidth-1:0] w_result;
    logic                 w_carry;
    logic                 w_zero;

    // Bit 8 of each 9-bit sum is carry-out; of each difference, the unsigned borrow
    assign w_add = {1'b0, i_a} + {1'b0, i_b};
    assign w_sub = {1'b0, i_a} - {1'b0, i_b};
    assign w_inc = {1'b0, i_a} + 9'd1;
    assign w_dec = {1'b0, i_a} - 9'd1;

    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        unique case (alu_op_e'(i_op))
            OpAdd:   {w_carry, w_result} = w_add;
            OpSub:   {w_carry, w_result} = w_sub;
            OpAnd:   w_result = i_a & i_b;
            OpOr:    w_result = i_a | i_b;
            OpXor:   w_result = i_a ^ i_b;
            OpNot:   w_result = ~i_a;
            OpShl: begin
                w_result = {i_a[6:0], 1'b0};
                w_carry  = i_a[7];
            end
            OpShr: begin
                w_result = {1'b0, i_a[7:1]};
                w_carry  = i_a[0];
            end
            OpSar: begin
                w_result = {i_a[7], i_a[7:1]};
                w_carry  = i_a[0];
            end
            OpRol: begin
                w_result = {i_a[6:0], i_a[7]};
                w_carry  = i_a[7];
            end
            OpRor: begin
                w_result = {i_a[0], i_a[7:1]};
                w_carry  = i_a[0];
            end
            OpInc:   {w_carry, w_result} = w_inc;
            OpDec:   {w_carry, w_result} = w_dec;
            OpPassA: w_result = i_a;
            OpPassB: w_result = i_b;
            OpCmp: begin
                w_result = i_a;
                w_carry  = w_sub[DataWidth];
            end
            default: begin
                w_result = '0;
                w_carry  = 1'b0;
            end
        endcase
    end

    // CMP reports Z on the difference, not on the passed-through A
    assign w_zero = (alu_op_e'(i_op) == OpCmp) ? (w_sub[DataWidth-1:0] == '0)
                                               : (w_result == '0);

    always_comb begin
        o_flags        = '0;
        o_flags[FlagZ] = w_zero;
        o_flags[FlagC] = w_carry;
    end

    assign o_result = w_result;

endmodule

// File: rtl/alu_core.sv
// 8-bit ALU top: combinational datapath followed by a single output register stage.
module alu_core
    import alu_core_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DataWidth-1:0] A,
    input  logic [DataWidth-1:0] B,
    input  logic [OpWidth-1:0]   op,
    output logic [DataWidth-1:0] E,
    output logic [CcWidth-1:0]   cc
);

    logic [DataWidth-1:0] w_result;
    logic [CcWidth-1:0]   w_flags;
    logic [DataWidth-1:0] r_e;
    logic [CcWidth-1:0]   r_cc;

    alu_comb u_alu_comb (
        .i_a      (A),
        .i_b      (B),
        .i_op     (op),
        .o_result (w_result),
        .o_flags  (w_flags)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e  <= '0;
            r_cc <= '0;
        end else begin
            r_e  <= w_result;
            r_cc <= w_flags;
        end
    end

    assign E  = r_e;
    assign cc = r_cc;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed corner vectors, async reset, randomized ops vs model.
module tb_alu_core;
    import alu_core_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [3:0] op_in;
    logic [7:0] e_out;
    logic [1:0] cc_out;

    int n_checks;
    int n_errors;

    alu_core dut (
        .clk (clk),
        .rst (rst),
        .A   (a_in),
        .B   (b_in),
        .op  (op_in),
        .E   (e_out),
        .cc  (cc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour in plain integer arithmetic; returns {C, Z, E}
    function automatic int model(input int a, input int b, input int opc);
        int e;
        int c;
        int z;
        e = 0;
        c = 0;
        case (opc)
            OpAdd:   begin e = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
            OpSub:   begin e = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            OpAnd:   e = a & b;
            OpOr:    e = a | b;
            OpXor:   e = a ^ b;
            OpNot:   e = 255 - a;
            OpShl:   begin e = (a * 2) % 256; c = a / 128; end
            OpShr:   begin e = a / 2; c = a % 2; end
            OpSar:   begin e = a / 2 + ((a >= 128) ? 128 : 0); c = a % 2; end
            OpRol:   begin e = (a * 2) % 256 + a / 128; c = a / 128; end
            OpRor:   begin e = a / 2 + (a % 2) * 128; c = a % 2; end
            OpInc:   begin e = (a + 1) % 256; c = (a == 255) ? 1 : 0; end
            OpDec:   begin e = (a + 255) % 256; c = (a == 0) ? 1 : 0; end
            OpPassA: e = a;
            OpPassB: e = b;
            default: begin e = a; c = (a < b) ? 1 : 0; end
        endcase
        z = (opc == OpCmp) ? ((a == b) ? 1 : 0) : ((e == 0) ? 1 : 0);
        return (c << 9) | (z << 8) | e;
    endfunction

    // Drive on the falling edge, sample 1 time unit after the next rising edge
    task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic [3:0] opc);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        op_in = opc;
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] opc, input logic [7:0] exp_e,
                            input logic [1:0] exp_cc);
        apply(a, b, opc);
        chk({tag, ".E"}, int'(e_out), int'(exp_e));
        chk({tag, ".cc"}, int'(cc_out), int'(exp_cc));
    endtask

    initial begin
        int exp_v;
        logic [7:0] held_e;
        logic [1:0] held_cc;
        n_checks = 0;
        n_errors = 0;
        a_in  = 8'h5A;
        b_in  = 8'hA5;
        op_in = 4'd0;
        rst   = 1'b1;
        #1;
        chk("reset_async_E", int'(e_out), 0);
        chk("reset_async_cc", int'(cc_out), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold_E", int'(e_out), 0);
        chk("reset_hold_cc", int'(cc_out), 0);
        @(negedge clk);
        rst = 1'b0;

        directed("add_3_2", 8'h03, 8'h02, 4'd0, 8'h05, 2'b00);
        directed("sub_eq", 8'h03, 8'h03, 4'd1, 8'h00, 2'b01);
        directed("sub_borrow", 8'h03, 8'h04, 4'd1, 8'hFF, 2'b10);
        directed("and_zero", 8'h03, 8'h04, 4'd2, 8'h00, 2'b01);
        directed("or", 8'h03, 8'h05, 4'd3, 8'h07, 2'b00);
        directed("add_wrap", 8'hFF, 8'h01, 4'd0, 8'h00, 2'b11);
        directed("shl", 8'h81, 8'h00, 4'd6, 8'h02, 2'b10);
        directed("sar", 8'h81, 8'h00, 4'd8, 8'hC0, 2'b10);
        directed("cmp_eq", 8'h05, 8'h05, 4'd15, 8'h05, 2'b01);
        directed("dec_zero", 8'h00, 8'h00, 4'd12, 8'hFF, 2'b10);
        directed("ror", 8'h01, 8'h00, 4'd10, 8'h80, 2'b10);

        // Inputs moving between edges must not reach the outputs
        held_e  = e_out;
        held_cc = cc_out;
        a_in  = 8'h7F;
        b_in  = 8'h01;
        op_in = 4'd0;
        #2;
        chk("between_edges_E", int'(e_out), int'(held_e));
        chk("between_edges_cc", int'(cc_out), int'(held_cc));

        // Reset asserted mid-cycle clears outputs without an edge
        rst = 1'b1;
        #1;
        chk("midreset_E", int'(e_out), 0);
        chk("midreset_cc", int'(cc_out), 0);
        @(posedge clk);
        #1;
        chk("midreset_hold_E", int'(e_out), 0);
        @(negedge clk);
        rst = 1'b0;
        directed("after_reset_add", 8'h03, 8'h02, 4'd0, 8'h05, 2'b00);

        for (int i = 0; i < 16; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            apply(ra, rb, 4'(i));
            exp_v = model(int'(ra), int'(rb), i);
            chk($sformatf("op%0d_E a=%0h b=%0h", i, ra, rb), int'(e_out), exp_v & 255);
            chk($sformatf("op%0d_cc a=%0h b=%0h", i, ra, rb), int'(cc_out), exp_v >> 8);
        end

        for (int i = 0; i < 400; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic [3:0] ro;
            ra = 8'($urandom);
            rb = (($urandom % 8) == 0) ? ra : 8'($urandom);
            ro = 4'($urandom);
            apply(ra, rb, ro);
            exp_v = model(int'(ra), int'(rb), int'(ro));
            chk($sformatf("rand_E op=%0d a=%0h b=%0h", ro, ra, rb), int'(e_out), exp_v & 255);
            chk($sformatf("rand_cc op=%0d a=%0h b=%0h", ro, ra, rb), int'(cc_out), exp_v >> 8);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  reset, asynchronous and active-high.
REQ-003 SHALL: A  input  8  operand A, unsigned/two's-complement.
REQ-004 SHALL: B  input  8  operand B.
REQ-005 SHALL: op  input  4  operation select.
REQ-006 SHALL: E  output  8  registered result.
REQ-007 SHALL: cc  output  2  registered condition code; cc[0]=Z (result zero), cc[1]=C (carry/borrow/shifted-out bit).

Function
REQ-008 SHALL: compute result and flags combinationally from A, B, op; register them into E/cc on each rising clk (latency exactly 1 cycle, no enable, updates every cycle).
REQ-009 SHALL: op encoding: 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 NOT A; 6 SHL A by 1; 7 SHR A logical by 1; 8 SAR A arithmetic by 1; 9 ROL A by 1; 10 ROR A by 1; 11 INC A; 12 DEC A; 13 PASS A; 14 PASS B; 15 CMP.
REQ-010 SHALL: all arithmetic modulo 2^8; E is the low 8 bits, no width extension.
REQ-011 SHALL: C for ADD/INC = carry out of bit 7; for SUB/DEC/CMP = borrow (1 when minuend < subtrahend, unsigned).
REQ-012 SHALL: C for SHL/ROL = old A[7]; for SHR/SAR/ROR = old A[0].
REQ-013 SHALL: C = 0 for AND, OR, XOR, NOT, PASS A, PASS B.
REQ-014 SHALL: CMP computes A-B for flags only; E = A; Z = 1 iff A == B.
REQ-015 SHALL: Z = 1 iff the 8-bit E value (for CMP: A-B) equals 0, for every op.
REQ-016 SHALL: ops 0-3 (ADD, SUB, AND, OR) are the primary set and must match exactly; op changes take effect on the next rising edge with no pipeline hazards or stalls.
REQ-017 SHALL: inputs changing between edges have no effect on outputs until the next edge.

Reset
REQ-018 SHALL: rst=1 immediately (without a clock edge) forces E=8'h00, cc=2'b00.
REQ-019 SHALL: while rst=1, E and cc hold 0 regardless of clk/inputs.
REQ-020 SHALL: first rising edge after rst deasserts loads the result of the inputs present at that edge.

Structure
REQ-021 SHALL: op-code constants (16 named values) and flag bit indices live in a shared package used by the ALU and its bench.
REQ-022 SHALL: combinational datapath is one sub-module alu_comb (A, B, op -> result, flags); alu_core adds only the output register.

Verification
REQ-023 SHALL: A=8'h03, B=8'h02, op=0, one edge -> E=8'h05, cc=2'b00.
REQ-024 SHALL: A=8'h03, B=8'h03, op=1 -> E=8'h00, cc=2'b01; A=8'h03, B=8'h04, op=1 -> E=8'hFF, cc=2'b10.
REQ-025 SHALL: A=8'h03, B=8'h04, op=2 -> E=8'h00, cc=2'b01; A=8'h03, B=8'h05, op=3 -> E=8'h07, cc=2'b00.
REQ-026 SHALL: A=8'hFF, B=8'h01, op=0 -> E=8'h00, cc=2'b11; A=8'h81, op=6 -> E=8'h02, cc=2'b10; A=8'h81, op=8 -> E=8'hC0, cc=2'b10.
REQ-027 SHALL: A=8'h05, B=8'h05, op=15 -> E=8'h05, cc=2'b01.
REQ-028 SHALL: assert rst mid-sequence between edges -> E=0, cc=0 immediately; release, apply A=3, B=2, op=0 -> E=5 after one edge.
